// File: rtl/imem_responder_if.sv
// Fetch request/response channel between fetch_unit (master) and imem_responder (slave).
`default_nettype none

interface imem_responder_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               resp_valid;
  logic               resp_ready;
  logic [INSTR_W-1:0] resp_instr;
  logic [ADDR_W-1:0]  resp_addr;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_addr
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_addr
  );
endinterface

`default_nettype wire

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency store read, in-order response FIFO,
// outstanding-count backpressure and flush.
`default_nettype none

module imem_responder #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 8,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  imem_responder_if.slave    bus,
  input  logic               flush,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               busy
);
  localparam int STAGES = LATENCY - 1;
  localparam int OUTS_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OUTS_W-1:0] DEPTH_C  = OUTS_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  logic [INSTR_W-1:0] store [2**ADDR_W];
  logic [STAGES:0]    vld_pipe;
  ent_t [STAGES:0]    dat_pipe;
  ent_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OUTS_W-1:0]  fcnt, outs;
  logic               acc, hs, fifo_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // outs covers pipeline plus FIFO, so gating on it alone keeps the FIFO from overflowing
  assign bus.req_ready  = !flush && (outs < DEPTH_C);
  assign acc            = bus.req_valid && bus.req_ready;
  assign hs             = bus.resp_valid && bus.resp_ready && !flush;
  assign fifo_wr        = vld_pipe[STAGES];
  assign bus.resp_valid = (fcnt != '0);
  assign bus.resp_instr = fifo_mem[rd_ptr].instr;
  assign bus.resp_addr  = fifo_mem[rd_ptr].addr;
  assign busy           = (outs != '0);

  // Store has no reset so its contents survive n_rst.
  always_ff @(posedge clk) begin
    if (n_rst && prog_we) store[prog_addr] <= prog_data;
  end

  // Read at the accept edge sees the pre-write word on an address collision.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= acc;
      dat_pipe[0] <= '{addr: bus.req_addr, instr: store[bus.req_addr]};
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] && !flush;
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= dat_pipe[STAGES];
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (hs) rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_wr, hs})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      outs <= '0;
    end else if (flush) begin
      outs <= '0;
    end else begin
      case ({acc, hs})
        2'b10:   outs <= outs + 1'b1;
        2'b01:   outs <= outs - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// Randomised + directed bench for imem_responder with a queue scoreboard.
`timescale 1ns/1ps

module tb_imem_responder;
  localparam int ADDR_W = 8, INSTR_W = 8, LATENCY = 2, FIFO_DEPTH = 4;

  logic clk = 1'b0, n_rst = 1'b0, flush = 1'b0, prog_we = 1'b0, busy;
  logic [ADDR_W-1:0]  prog_addr = '0;
  logic [INSTR_W-1:0] prog_data = '0;

  imem_responder_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();

  imem_responder #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .LATENCY(LATENCY),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus), .flush(flush), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, edges = 0;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
    int                 ready_at;
  } exp_t;

  exp_t               sbq[$];
  exp_t               ent;
  logic [INSTR_W-1:0] ref_mem [2**ADDR_W];
  logic               mon_rv;
  logic [INSTR_W-1:0] col [4];
  logic [ADDR_W-1:0]  col_a [4];
  int                 got;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
    end
  endfunction

  always @(posedge clk) edges <= edges + 1;

  // Reference: outstanding = queue length; head is visible LATENCY edges after its accept.
  always @(negedge clk) begin
    if (!n_rst) begin
      sbq.delete();
    end else begin
      chk("sb_busy", busy, sbq.size() != 0);
      chk("sb_req_ready", bus.req_ready, !flush && (sbq.size() < FIFO_DEPTH));
      mon_rv = (sbq.size() > 0) && (edges >= sbq[0].ready_at);
      chk("sb_resp_valid", bus.resp_valid, mon_rv);
      if (mon_rv && bus.resp_valid) begin
        chk("sb_resp_instr", bus.resp_instr, sbq[0].instr);
        chk("sb_resp_addr", bus.resp_addr, sbq[0].addr);
      end
      if (flush) begin
        sbq.delete();
      end else begin
        if (bus.resp_valid && bus.resp_ready && sbq.size() > 0) void'(sbq.pop_front());
        if (bus.req_valid && bus.req_ready) begin
          ent.addr     = bus.req_addr;
          ent.instr    = ref_mem[bus.req_addr];
          ent.ready_at = edges + 1 + LATENCY;
          sbq.push_back(ent);
        end
      end
      if (prog_we) ref_mem[prog_addr] = prog_data;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(string nm);
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1; flush = 1'b0; prog_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nxt();
    end
    chk(nm, busy, 1'b0);
    nxt();
  endtask

  task automatic collect(int n);
    got = 0;
    for (int i = 0; i < 30 && got < n; i++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) begin
        col[got]   = bus.resp_instr;
        col_a[got] = bus.resp_addr;
        got++;
      end
      nxt();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_n;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_instr", bus.resp_instr, 0);
    chk("rst_resp_addr", bus.resp_addr, 0);
    chk("rst_busy", busy, 1'b0);
    nxt();
    n_rst = 1'b1;

    for (int a = 0; a < 2**ADDR_W; a++) begin
      prog_we = 1'b1; prog_addr = ADDR_W'(a);
      if (a < 4)       prog_data = INSTR_W'(8'h10 + a);
      else if (a == 5) prog_data = 8'h35;
      else if (a == 7) prog_data = 8'h55;
      else             prog_data = INSTR_W'($urandom);
      nxt();
    end
    prog_we = 1'b0;
    nxt();

    // Back-to-back throughput
    bus.resp_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      bus.req_valid = (j < 4);
      bus.req_addr  = ADDR_W'((j < 4) ? j : 0);
      @(negedge clk);
      if (j >= 3 && j <= 6) begin
        chk("tp_valid", bus.resp_valid, 1'b1);
        chk("tp_instr", bus.resp_instr, 8'h10 + j - 3);
        chk("tp_addr", bus.resp_addr, j - 3);
      end else begin
        chk("tp_idle", bus.resp_valid, 1'b0);
      end
      nxt();
    end

    // Backpressure
    bus.resp_ready = 1'b0; bus.req_valid = 1'b1; acc_n = 0;
    for (int j = 0; j < 8; j++) begin
      bus.req_addr = ADDR_W'(acc_n);
      @(negedge clk);
      if (bus.req_ready) acc_n++;
      nxt();
    end
    @(negedge clk);
    chk("bp_accepts", acc_n, FIFO_DEPTH);
    chk("bp_req_ready", bus.req_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    chk("bp_head", bus.resp_instr, 8'h10);
    nxt();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_comb_path", bus.req_ready, 1'b0);
    chk("bp_hold", bus.resp_instr, 8'h10);
    nxt();
    bus.resp_ready = 1'b0; bus.req_addr = 8'd4;
    @(negedge clk);
    chk("bp_ready_rise", bus.req_ready, 1'b1);
    chk("bp_next_head", bus.resp_instr, 8'h11);
    nxt();
    @(negedge clk);
    chk("bp_refull", bus.req_ready, 1'b0);
    nxt();

    // Accept and drain together at full
    bus.resp_ready = 1'b1; bus.req_addr = 8'd5;
    @(negedge clk);
    chk("full_ready_low", bus.req_ready, 1'b0);
    nxt();
    for (int j = 0; j < 5; j++) begin
      bus.req_addr = ADDR_W'(j + 1);
      @(negedge clk);
      chk("full_ready_high", bus.req_ready, 1'b1);
      chk("full_busy", busy, 1'b1);
      nxt();
    end
    drain("full_drain");

    // Flush mid-flight
    bus.resp_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      bus.req_valid = 1'b1; bus.req_addr = ADDR_W'(j);
      nxt();
    end
    flush = 1'b1; bus.req_addr = 8'd4;
    @(negedge clk);
    chk("fl_req_ready", bus.req_ready, 1'b0);
    nxt();
    flush = 1'b0; bus.req_addr = 8'd5; bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("fl_resp_valid", bus.resp_valid, 1'b0);
    chk("fl_busy", busy, 1'b0);
    chk("fl_ready_after", bus.req_ready, 1'b1);
    nxt();
    bus.req_valid = 1'b0;
    collect(1);
    chk("fl_count", got, 1);
    chk("fl_instr", col[0], 8'h35);
    chk("fl_addr", col_a[0], 8'd5);
    @(negedge clk);
    chk("fl_busy_end", busy, 1'b0);
    nxt();

    // Write collision
    prog_we = 1'b1; prog_addr = 8'd7; prog_data = 8'hAA;
    bus.req_valid = 1'b1; bus.req_addr = 8'd7; bus.resp_ready = 1'b1;
    nxt();
    prog_we = 1'b0;
    nxt();
    bus.req_valid = 1'b0;
    collect(2);
    chk("wc_count", got, 2);
    chk("wc_old", col[0], 8'h55);
    chk("wc_new", col[1], 8'hAA);

    // Reset mid-operation
    bus.resp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.req_valid = 1'b1; bus.req_addr = ADDR_W'(j);
      nxt();
    end
    bus.req_valid = 1'b0;
    n_rst = 1'b0; prog_we = 1'b1; prog_addr = 8'd0; prog_data = 8'hEE;
    #1;
    chk("mr_resp_valid", bus.resp_valid, 1'b0);
    chk("mr_req_ready", bus.req_ready, 1'b1);
    chk("mr_busy", busy, 1'b0);
    nxt();
    nxt();
    n_rst = 1'b1; prog_we = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 8'd0; bus.resp_ready = 1'b1;
    nxt();
    bus.req_valid = 1'b0;
    collect(1);
    chk("mr_count", got, 1);
    chk("mr_store_kept", col[0], 8'h10);

    // Random traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid  = ($urandom_range(0, 9) < 6);
      bus.req_addr   = ADDR_W'($urandom);
      bus.resp_ready = ($urandom_range(0, 9) < 7);
      flush          = ($urandom_range(0, 49) == 0);
      prog_we        = ($urandom_range(0, 4) == 0);
      prog_addr      = ADDR_W'($urandom);
      prog_data      = INSTR_W'($urandom);
      nxt();
    end
    drain("rnd_drain");
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory-side end of the fetch request/response protocol driven by `fetch_unit`. It accepts instruction-address requests with a valid/ready handshake, reads a local instruction store, and returns instructions in request order after a fixed pipeline latency. A bounded response FIFO and an outstanding-request counter provide backpressure. A flush input discards all in-flight work on branch mispredict or redirect. The store is loaded through a separate program-write port.

## Interface
- `ADDR_W`, 8, instruction address width; store depth is 2**ADDR_W words.
- `INSTR_W`, 8, instruction word width.
- `LATENCY`, 2, accept-to-response latency in cycles; legal range 1..4.
- `FIFO_DEPTH`, 4, response buffer entries; must be ≥ LATENCY+1.
- `clk`  in  1  single clock, rising edge.
- `n_rst`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_addr`  in  ADDR_W  instruction address.
- `resp_valid`  out  1  response at FIFO head.
- `resp_ready`  in  1  fetch side consumes the response.
- `resp_instr`  out  INSTR_W  instruction word.
- `resp_addr`  out  ADDR_W  address that produced `resp_instr`.
- `flush`  in  1  discard all outstanding requests and responses.
- `prog_we`  in  1  program-store write enable.
- `prog_addr`  in  ADDR_W  program write address.
- `prog_data`  in  INSTR_W  program write data.
- `busy`  out  1  outstanding count is nonzero.

## Operation
- Accept: `req_valid && req_ready` at a rising edge. The store is read at that edge.
- Read-before-write: a same-cycle `prog_we` to the same address returns the old word. The write still lands.
- Stored word and address travel through a valid-tagged delay pipeline, then enter the FIFO.
- Responses leave strictly in acceptance order.
- Outstanding counter `outs`, width clog2(FIFO_DEPTH+1):
  - +1 on accept, −1 on response handshake (`resp_valid && resp_ready`).
  - Unchanged when both occur in the same cycle.
  - Cleared to 0 by flush.
- `req_ready = !flush && (outs < FIFO_DEPTH)`. Because `outs` counts both pipeline and FIFO entries, the FIFO can never overflow.
- FIFO write on pipeline exit and FIFO read on handshake may coincide in the same cycle, including when the FIFO is full.
- `resp_valid` = FIFO not empty. `resp_instr` and `resp_addr` come from the FIFO head and hold stable while `resp_valid && !resp_ready`.
- Flush, at the edge where `flush` is high:
  - all pipeline valid bits cleared;
  - FIFO emptied;
  - `outs` set to 0;
  - a same-cycle request is not accepted (`req_ready` is low);
  - a same-cycle response handshake is ignored (the entry is discarded anyway).
- Program store is a plain array with no reset (not cleared). `prog_we` while `n_rst` is low is ignored.
- `busy = (outs != 0)`.

## Timing
- Reset values (async, take effect immediately): `req_ready`=1, `resp_valid`=0, `resp_instr`=0, `resp_addr`=0, `busy`=0, `outs`=0, pipeline valids=0, FIFO pointers=0.
- Reset mid-operation drops all in-flight requests silently. The store contents are kept. The first accept is possible in the first cycle after `n_rst` rises.
- Latency: request accepted at edge k → `resp_valid` high after edge k+LATENCY, provided earlier responses have drained.
- Throughput: one request per cycle sustained when `resp_ready` is held high.
- Backpressure: with `resp_ready` low, exactly FIFO_DEPTH requests are accepted, then `req_ready` falls. It rises the cycle after the first response handshake.
- Flush: `resp_valid`=0 and `busy`=0 in the cycle after the flush edge. A new request may be accepted in that cycle.
- Combinational paths:
  - `req_ready` depends on `flush` and `outs` only.
  - `resp_valid` is registered state.
  - No path exists from `resp_ready` to `req_ready` within a cycle.

## Test plan
- Throughput, LATENCY=2: program store words 0x10..0x13 at addresses 0..3. Issue back-to-back requests 0,1,2,3 with `resp_ready`=1 → responses 0x10,0x11,0x12,0x13 on four consecutive cycles. The first appears 2 cycles after the first accept; `resp_addr` matches.
- Backpressure: hold `resp_ready`=0 and keep `req_valid`=1 → exactly 4 accepts, then `req_ready`=0 and `busy`=1. Pulse `resp_ready` for one cycle → one response with `resp_instr` unchanged before the pulse, then one further accept.
- Simultaneous accept and drain at full: with `outs`=4 and `resp_ready`=1, `req_ready` rises the cycle after the handshake. After the next accept+drain edge, `outs` stays 4 and no entry is lost or duplicated.
- Flush mid-flight: accept 3 requests, assert `flush` 1 cycle after the third accept with `req_valid`=1 → that request is not accepted; `resp_valid`=0 and `busy`=0 next cycle. A new request to address 5 returns only store[5].
- Write collision: `prog_we` writes 0xAA to address 7 in the same cycle that a request for 7 is accepted (old value 0x55) → response 0x55. A following request for 7 → 0xAA.
- Reset mid-operation: drop `n_rst` with 3 requests outstanding → `resp_valid`=0 and `req_ready`=1 immediately. After release, reading address 0 returns the pre-reset store contents.
